// File: rtl/aes_sched_pkg.sv
// Shared types for the two-requester AES job scheduler.
package aes_sched_pkg;

  localparam int unsigned CNT_W     = 10;
  localparam int unsigned KEY_MAX_W = 256;
  localparam int unsigned BLK_W     = 128;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    WAIT,
    RESP
  } sched_state_t;

  // Key field is sized for the widest key; the scheduler uses the low K bits.
  typedef struct packed {
    logic [KEY_MAX_W-1:0] key;
    logic [BLK_W-1:0]     msg;
    logic                 dir;
  } aes_job_t;

endpackage

// File: rtl/aes_sched_if.sv
// Job request / response channels between job sources and the scheduler.
interface aes_sched_if #(
  parameter int unsigned K = 128
);

  logic [1:0]          req_valid;
  logic [1:0]          req_ready;
  logic [1:0][K-1:0]   req_key;
  logic [1:0][127:0]   req_msg;
  logic [1:0]          req_dir;

  logic                rsp_valid;
  logic                rsp_ready;
  logic                rsp_id;
  logic [127:0]        rsp_data;
  logic                rsp_err;

  modport master (
    output req_valid, req_key, req_msg, req_dir, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

  modport slave (
    input  req_valid, req_key, req_msg, req_dir, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_data, rsp_err
  );

endinterface

// File: rtl/aes_sched_rr_arb2.sv
// Two-input round-robin arbiter; prio names the requester favoured on contention.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       prio,
  input  logic       en,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (en) begin
      case (req)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = prio ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/aes_sched.sv
// Shares one aes_core between two requesters: round-robin accept, load/done sequencing,
// tagged response with timeout error.
module aes_sched
  import aes_sched_pkg::*;
#(
  parameter int unsigned K        = 128,
  parameter int unsigned LOAD_CYC = 2,
  parameter int unsigned TIMEOUT  = 64
) (
  input  logic          clk,
  input  logic          reset_n,
  aes_sched_if.slave    bus,
  output logic          core_load,
  output logic [K-1:0]  core_key,
  output logic [127:0]  core_msg,
  output logic          core_dir,
  input  logic          core_done,
  input  logic [127:0]  core_out,
  output logic          busy
);

  if (!(K == 128 || K == 192 || K == 256)) begin : gen_bad_k
    $error("aes_sched: K must be 128, 192 or 256");
  end
  if (LOAD_CYC < 1 || LOAD_CYC > 15) begin : gen_bad_load
    $error("aes_sched: LOAD_CYC must be in 1..15");
  end
  if (TIMEOUT < 2 || TIMEOUT > 1023) begin : gen_bad_timeout
    $error("aes_sched: TIMEOUT must be in 2..1023");
  end

  localparam logic [CNT_W-1:0] LoadInit = CNT_W'(LOAD_CYC - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);

  sched_state_t     state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  aes_job_t         job_q, job_d;
  logic [127:0]     data_q, data_d;
  logic             err_q, err_d;

  logic [1:0]       gnt;
  logic             gnt_id;
  logic             arb_en;
  logic             unused_key;

  assign arb_en = (state_q == IDLE);

  rr_arb2 u_arb (
    .req  (bus.req_valid),
    .prio (prio_q),
    .en   (arb_en),
    .gnt  (gnt)
  );

  assign gnt_id = gnt[1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    prio_d  = prio_q;
    id_d    = id_q;
    job_d   = job_q;
    data_d  = data_q;
    err_d   = err_q;

    unique case (state_q)
      IDLE: begin
        // A grant is only ever issued to a valid requester, so a grant is a transfer.
        if (|gnt) begin
          job_d.key          = '0;
          job_d.key[K-1:0]   = bus.req_key[gnt_id];
          job_d.msg          = bus.req_msg[gnt_id];
          job_d.dir          = bus.req_dir[gnt_id];
          id_d               = gnt_id;
          prio_d             = ~gnt_id;
          cnt_d              = LoadInit;
          state_d            = LOAD;
        end
      end
      LOAD: begin
        if (cnt_q == '0) begin
          cnt_d   = '0;
          state_d = WAIT;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      WAIT: begin
        // done is checked first so it wins a same-cycle collision with the timeout.
        if (core_done) begin
          data_d  = core_out;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (cnt_q == TimeoutLast) begin
          data_d  = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RESP: begin
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      prio_q  <= 1'b0;
      id_q    <= 1'b0;
      job_q   <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      prio_q  <= prio_d;
      id_q    <= id_d;
      job_q   <= job_d;
      data_q  <= data_d;
      err_q   <= err_d;
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = (state_q == RESP);
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;

  // Decoded from the async-reset state register, so it drops as soon as reset asserts.
  assign core_load = (state_q == LOAD);
  assign core_key  = job_q.key[K-1:0];
  assign core_msg  = job_q.msg;
  assign core_dir  = job_q.dir;
  assign busy      = (state_q != IDLE);

  assign unused_key = ^job_q.key;

endmodule
